// File: rtl/regfile_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader_if
// Purpose  : Dump-stream bundle between the register file dump reader and
//            its debug/trace consumer (start/busy/done plus valid/ready beat).
// Revision : 1.0  initial release
// ============================================================================
interface regfile_dump_reader_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              dumpStart;
    logic              dumpReady;
    logic              dumpValid;
    logic [ADDR_W-1:0] dumpAddr;
    logic [WIDTH-1:0]  dumpData;
    logic              dumpBusy;
    logic              dumpDone;

    // Register file side: produces the beats.
    modport master (
        input  dumpStart,
        input  dumpReady,
        output dumpValid,
        output dumpAddr,
        output dumpData,
        output dumpBusy,
        output dumpDone
    );

    // Consumer side: requests the dump and accepts beats.
    modport slave (
        output dumpStart,
        output dumpReady,
        input  dumpValid,
        input  dumpAddr,
        input  dumpData,
        input  dumpBusy,
        input  dumpDone
    );
endinterface
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_reader
// Purpose  : MIPS GPR file, one write port, two combinational read ports with
//            same-cycle write bypass, and a sequential dump reader streaming
//            (address, data) beats over a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module regfile_dump_reader #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              write,
    input  wire logic [ADDR_W-1:0] writeReg,
    input  wire logic [WIDTH-1:0]  writeData,
    input  wire logic [ADDR_W-1:0] readReg1,
    input  wire logic [ADDR_W-1:0] readReg2,
    output logic      [WIDTH-1:0]  readData1,
    output logic      [WIDTH-1:0]  readData2,
    regfile_dump_reader_if.master  dump
);

    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_send = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [WIDTH-1:0]  r_regs [DEPTH];
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_data;
    logic              r_busy;
    logic              r_done;

    logic              w_write_ok;
    logic [WIDTH-1:0]  w_load_data;

    // Register 0 and indices beyond DEPTH are not real storage.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && ({1'b0, a} < c_depth);
    endfunction

    // Read value seen by any read port: zero for unbacked addresses, the
    // in-flight write data when it targets the same register, else storage.
    function automatic logic [WIDTH-1:0] read_value(
        input logic [ADDR_W-1:0] a,
        input logic [WIDTH-1:0]  stored,
        input logic              wen,
        input logic [ADDR_W-1:0] wreg,
        input logic [WIDTH-1:0]  wdata
    );
        if (!addr_ok(a))
            return '0;
        else if (wen && (wreg == a))
            return wdata;
        else
            return stored;
    endfunction

    assign w_write_ok  = write && addr_ok(writeReg);
    assign readData1   = read_value(readReg1, r_regs[readReg1], write, writeReg, writeData);
    assign readData2   = read_value(readReg2, r_regs[readReg2], write, writeReg, writeData);
    // The dump snapshot obeys the same bypass rules as the read ports.
    assign w_load_data = read_value(r_ptr, r_regs[r_ptr], write, writeReg, writeData);

    assign dump.dumpValid = r_valid;
    assign dump.dumpAddr  = r_addr;
    assign dump.dumpData  = r_data;
    assign dump.dumpBusy  = r_busy;
    assign dump.dumpDone  = r_done;

    // Register storage: cleared by reset, written only for real registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                r_regs[i] <= '0;
        end else if (w_write_ok) begin
            r_regs[writeReg] <= writeData;
        end
    end

    // Dump sequencer: LOAD snapshots one register, SEND holds it until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (dump.dumpStart) begin
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_load;
                    end
                end
                c_st_load: begin
                    r_addr  <= r_ptr;
                    r_data  <= w_load_data;
                    r_valid <= 1'b1;
                    r_state <= c_st_send;
                end
                c_st_send: begin
                    if (r_valid && dump.dumpReady) begin
                        r_valid <= 1'b0;
                        if (r_ptr == c_last) begin
                            r_done  <= 1'b1;
                            r_state <= c_st_done;
                        end else begin
                            r_ptr   <= r_ptr + 1'b1;
                            r_state <= c_st_load;
                        end
                    end
                end
                c_st_done: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump_reader
// Purpose  : Directed self-checking bench for regfile_dump_reader.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_dump_reader;

    logic        clk;
    logic        reset;
    logic        write;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] readData1;
    logic [31:0] readData2;

    int total = 0;
    int bad   = 0;

    regfile_dump_reader_if #(.WIDTH(32), .ADDR_W(5)) dif ();

    regfile_dump_reader #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .writeReg  (writeReg),
        .writeData (writeData),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .dump      (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int beats;
        int done_cnt;
        int done_cyc;
        int busy_fall;
        int post_valid;
        bit stalled;
        bit found;

        reset         = 1'b1;
        write         = 1'b0;
        writeReg      = '0;
        writeData     = '0;
        readReg1      = '0;
        readReg2      = '0;
        dif.dumpStart = 1'b0;
        dif.dumpReady = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // ---- 1: asynchronous reset clears state mid-cycle ----
        write = 1'b1; writeReg = 5'd7; writeData = 32'h0000_5A5A;
        @(negedge clk);
        write = 1'b0; readReg1 = 5'd7;
        #1 check("t1_pre_reset_read", 64'(readData1), 64'h5A5A);
        #2 reset = 1'b1;
        #1;
        check("t1_read7_zero", 64'(readData1), 64'h0);
        check("t1_valid", 64'(dif.dumpValid), 64'h0);
        check("t1_addr",  64'(dif.dumpAddr),  64'h0);
        check("t1_data",  64'(dif.dumpData),  64'h0);
        check("t1_busy",  64'(dif.dumpBusy),  64'h0);
        check("t1_done",  64'(dif.dumpDone),  64'h0);
        @(negedge clk);
        reset = 1'b0;

        // ---- 2: write bypass ----
        @(negedge clk);
        write = 1'b1; writeReg = 5'd5; writeData = 32'hDEAD_BEEF;
        readReg1 = 5'd5; readReg2 = 5'd6;
        #1;
        check("t2_bypass", 64'(readData1), 64'hDEAD_BEEF);
        check("t2_other_port", 64'(readData2), 64'h0);
        @(negedge clk);
        write = 1'b0;
        #1 check("t2_after_edge", 64'(readData1), 64'hDEAD_BEEF);

        // ---- 3: register 0 is hardwired zero ----
        @(negedge clk);
        write = 1'b1; writeReg = 5'd0; writeData = 32'h0000_1234; readReg2 = 5'd0;
        #1 check("t3_r0_during", 64'(readData2), 64'h0);
        @(negedge clk);
        write = 1'b0;
        #1 check("t3_r0_after", 64'(readData2), 64'h0);

        // ---- 4: full dump with ready held high ----
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            write = 1'b1; writeReg = 5'(i); writeData = 32'(i * 3);
        end
        @(negedge clk);
        write = 1'b0;
        readReg1 = 5'd31;
        #1 check("t4_preload_r31", 64'(readData1), 64'd93);
        dif.dumpReady = 1'b1;
        dif.dumpStart = 1'b1;
        @(negedge clk);
        dif.dumpStart = 1'b0;
        beats = 0; done_cnt = 0; done_cyc = -1; busy_fall = -1;
        for (int c = 1; c <= 80; c++) begin
            if (c == 1) begin
                check("t4_busy_c1",  64'(dif.dumpBusy),  64'h1);
                check("t4_valid_c1", 64'(dif.dumpValid), 64'h0);
            end
            if (dif.dumpValid) begin
                check("t4_addr", 64'(dif.dumpAddr), 64'(beats));
                check("t4_data", 64'(dif.dumpData), 64'(beats * 3));
                check("t4_beat_cycle", 64'(c), 64'(2 * beats + 2));
                beats++;
            end
            if (dif.dumpDone) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (!dif.dumpBusy && busy_fall < 0) busy_fall = c;
            @(negedge clk);
        end
        check("t4_beats", 64'(beats), 64'd32);
        check("t4_done_cnt", 64'(done_cnt), 64'd1);
        check("t4_done_cyc", 64'(done_cyc), 64'd65);
        check("t4_busy_fall", 64'(busy_fall), 64'd66);

        // ---- 5: back-pressure stall, write during stall, ignored start ----
        dif.dumpStart = 1'b1;
        @(negedge clk);
        dif.dumpStart = 1'b0;
        beats = 0; done_cnt = 0; post_valid = 0; stalled = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            if (dif.dumpValid) begin
                if (done_cnt != 0) post_valid++;
                check("t5_addr", 64'(dif.dumpAddr), 64'(beats));
                check("t5_data", 64'(dif.dumpData), 64'(beats * 3));
                beats++;
                if (dif.dumpAddr == 5'd4 && !stalled) begin
                    stalled = 1'b1;
                    dif.dumpReady = 1'b0;
                    for (int s = 0; s < 10; s++) begin
                        @(negedge clk);
                        check("t5_stall_valid", 64'(dif.dumpValid), 64'h1);
                        check("t5_stall_addr",  64'(dif.dumpAddr),  64'd4);
                        check("t5_stall_data",  64'(dif.dumpData),  64'd12);
                        if (s == 2) begin
                            write = 1'b1; writeReg = 5'd4; writeData = 32'hCAFE_0004;
                        end
                        if (s == 3) write = 1'b0;
                        if (s == 5) dif.dumpStart = 1'b1;
                        if (s == 6) dif.dumpStart = 1'b0;
                    end
                    dif.dumpReady = 1'b1;
                end
            end
            if (dif.dumpDone) done_cnt++;
            @(negedge clk);
        end
        check("t5_stalled", 64'(stalled), 64'h1);
        check("t5_beats", 64'(beats), 64'd32);
        check("t5_done_cnt", 64'(done_cnt), 64'd1);
        check("t5_no_requeue", 64'(post_valid), 64'd0);
        check("t5_busy_end", 64'(dif.dumpBusy), 64'h0);
        readReg1 = 5'd4;
        #1 check("t5_reg4_written", 64'(readData1), 64'hCAFE_0004);

        // ---- 6: reset mid-dump aborts, new dump restarts at 0 ----
        @(negedge clk);
        dif.dumpStart = 1'b1;
        @(negedge clk);
        dif.dumpStart = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (dif.dumpValid && dif.dumpAddr == 5'd12) found = 1'b1;
            else @(negedge clk);
        end
        check("t6_reached_beat12", 64'(found), 64'h1);
        check("t6_beat12_data", 64'(dif.dumpData), 64'd36);
        #2 reset = 1'b1;
        #1;
        check("t6_valid", 64'(dif.dumpValid), 64'h0);
        check("t6_busy",  64'(dif.dumpBusy),  64'h0);
        check("t6_done",  64'(dif.dumpDone),  64'h0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (dif.dumpDone || dif.dumpValid) done_cnt++;
        end
        check("t6_quiet_after_reset", 64'(done_cnt), 64'd0);
        dif.dumpStart = 1'b1;
        @(negedge clk);
        dif.dumpStart = 1'b0;
        @(negedge clk);
        check("t6_restart_valid", 64'(dif.dumpValid), 64'h1);
        check("t6_restart_addr",  64'(dif.dumpAddr),  64'd0);
        check("t6_restart_data",  64'(dif.dumpData),  64'd0);
        repeat (2) @(negedge clk);
        check("t6_beat1_addr", 64'(dif.dumpAddr), 64'd1);
        check("t6_beat1_data", 64'(dif.dumpData), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
